// File: rtl/clk_pkg.sv
// Shared constants, state encoding and hour folding for clk_timekeeper.
// Used by every file of the block via import clk_pkg::*.
package clk_pkg;

   localparam logic [5:0] TICKS_PER_REV = 6'd60;
   localparam logic [5:0] SEC_MAX       = 6'd59;
   localparam logic [5:0] MIN_MAX       = 6'd59;
   localparam logic [3:0] HR12_MAX      = 4'd11;
   localparam logic [4:0] HR24_MAX      = 5'd23;

   typedef enum logic {
      UNSYNCED,
      RUNNING
   } tk_state_t;

   function automatic logic [3:0] to_hr12(input logic [4:0] h);
      return (h > 5'(HR12_MAX)) ? 4'(h - 5'd12) : h[3:0];
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to one wrap strobe per CLK_HZ enabled cycles.
// clr restarts the count so a fresh second begins on the next cycle.
module sec_prescaler
   import clk_pkg::*;
#(
   parameter int CLK_HZ = 40000000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] r_cnt;

   assign wrap = en && (r_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= wrap ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/clk_timekeeper.sv
// Analogue-dial timekeeper: loads a 24h frame, runs a 12h clock.
// Define CLK_TIMEKEEPER_SMOOTH_HOUR_EN to let the hour hand creep with minutes.
module clk_timekeeper
   import clk_pkg::*;
#(
   parameter int CLK_HZ = 40000000,
   parameter int SYNC_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [4:0]        hour_in,
   input  logic [5:0]        minute_in,
   input  logic [5:0]        second_in,
   output logic [5:0]        second,
   output logic [5:0]        minute,
   output logic [5:0]        hour,
   output logic              sec_pulse,
   output logic              synced,
   output logic              load_err,
   output logic [SYNC_W-1:0] synccounter
);

   tk_state_t r_state;
   tk_state_t w_state_nxt;

   logic [3:0]        r_hr;
   logic [5:0]        r_min;
   logic [5:0]        r_sec;
   logic [SYNC_W-1:0] r_sync_cnt;
   logic              r_sec_pulse;
   logic              r_load_err;

   logic       w_fits;
   logic       w_accept;
   logic       w_reject;
   logic       w_wrap;
   logic       w_tick;
   logic [5:0] w_hour_pos;

   assign w_fits = (hour_in <= HR24_MAX)
                && (minute_in < TICKS_PER_REV)
                && (second_in <= SEC_MAX);
   assign w_accept = load_valid && w_fits;
   assign w_reject = load_valid && !w_fits;
   // A load on the wrap cycle restarts the second instead of counting it.
   assign w_tick   = w_wrap && !w_accept;

   sec_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (r_state == RUNNING),
      .clr   (w_accept),
      .wrap  (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= UNSYNCED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = RUNNING;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hr        <= '0;
         r_min       <= '0;
         r_sec       <= '0;
         r_sync_cnt  <= '0;
         r_sec_pulse <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_sec_pulse <= w_tick;
         r_load_err  <= w_reject;
         if (w_accept) begin
            r_hr       <= to_hr12(hour_in);
            r_min      <= minute_in;
            r_sec      <= second_in;
            r_sync_cnt <= '0;
         end else if (w_tick) begin
            if (r_sync_cnt != {SYNC_W{1'b1}}) begin
               r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
            end
            if (r_sec == SEC_MAX) begin
               r_sec <= '0;
               if (r_min == MIN_MAX) begin
                  r_min <= '0;
                  r_hr  <= (r_hr == HR12_MAX) ? 4'd0 : r_hr + 4'd1;
               end else begin
                  r_min <= r_min + 6'd1;
               end
            end else begin
               r_sec <= r_sec + 6'd1;
            end
         end
      end
   end

`ifdef CLK_TIMEKEEPER_SMOOTH_HOUR_EN
   assign w_hour_pos = ({2'b00, r_hr} * 6'd5) + (r_min / 6'd12);
`else
   assign w_hour_pos = {2'b00, r_hr} * 6'd5;
`endif

   assign second      = r_sec;
   assign minute      = r_min;
   assign hour        = w_hour_pos;
   assign sec_pulse   = r_sec_pulse;
   assign synced      = (r_state == RUNNING);
   assign load_err    = r_load_err;
   assign synccounter = r_sync_cnt;

endmodule

// File: tb/tb_clk_timekeeper.sv
// Directed bench for clk_timekeeper at CLK_HZ=10 (one second = 10 clocks).
// Inputs change and outputs are sampled on the falling edge.
module tb_clk_timekeeper;

   localparam int CLK_HZ = 10;
   localparam int SYNC_W = 16;

   logic              clk;
   logic              reset;
   logic              load_valid;
   logic [4:0]        hour_in;
   logic [5:0]        minute_in;
   logic [5:0]        second_in;
   logic [5:0]        second;
   logic [5:0]        minute;
   logic [5:0]        hour;
   logic              sec_pulse;
   logic              synced;
   logic              load_err;
   logic [SYNC_W-1:0] synccounter;

   int n_pass;
   int n_total;
   int n_pulse;
   int n_err;

   clk_timekeeper #(
      .CLK_HZ (CLK_HZ),
      .SYNC_W (SYNC_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .hour_in     (hour_in),
      .minute_in   (minute_in),
      .second_in   (second_in),
      .second      (second),
      .minute      (minute),
      .hour        (hour),
      .sec_pulse   (sec_pulse),
      .synced      (synced),
      .load_err    (load_err),
      .synccounter (synccounter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (sec_pulse === 1'b1) n_pulse++;
      if (load_err === 1'b1) n_err++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [4:0] h,
                       input logic [5:0] m,
                       input logic [5:0] s);
      load_valid = 1'b1;
      hour_in    = h;
      minute_in  = m;
      second_in  = s;
      step(1);
      load_valid = 1'b0;
   endtask

   task automatic chk_time(input string tag,
                           input logic [5:0] h,
                           input logic [5:0] m,
                           input logic [5:0] s);
      chk({tag, ".hour"}, 32'(hour), 32'(h));
      chk({tag, ".minute"}, 32'(minute), 32'(m));
      chk({tag, ".second"}, 32'(second), 32'(s));
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      n_pulse    = 0;
      n_err      = 0;
      reset      = 1'b1;
      load_valid = 1'b0;
      hour_in    = '0;
      minute_in  = '0;
      second_in  = '0;
      step(2);
      reset = 1'b0;

      chk_time("rst", 6'd0, 6'd0, 6'd0);
      chk("rst.synced", 32'(synced), 32'd0);
      chk("rst.synccounter", 32'(synccounter), 32'd0);
      chk("rst.load_err", 32'(load_err), 32'd0);
      n_pulse = 0;
      step(50);
      chk("idle.pulses", 32'(n_pulse), 32'd0);
      chk("idle.synced", 32'(synced), 32'd0);
      chk_time("idle", 6'd0, 6'd0, 6'd0);

      load(5'd13, 6'd7, 6'd58);
      chk_time("ld13", 6'd5, 6'd7, 6'd58);
      chk("ld13.synced", 32'(synced), 32'd1);
      chk("ld13.synccounter", 32'(synccounter), 32'd0);
      step(9);
      chk("ld13.c9.second", 32'(second), 32'd58);
      chk("ld13.c9.pulse", 32'(sec_pulse), 32'd0);
      step(1);
      chk("ld13.c10.second", 32'(second), 32'd59);
      chk("ld13.c10.pulse", 32'(sec_pulse), 32'd1);
      step(1);
      chk("ld13.c11.pulse", 32'(sec_pulse), 32'd0);
      step(9);
      chk_time("ld13.c20", 6'd5, 6'd8, 6'd0);
      chk("ld13.c20.synccounter", 32'(synccounter), 32'd2);

      load(5'd11, 6'd59, 6'd59);
`ifdef CLK_TIMEKEEPER_SMOOTH_HOUR_EN
      chk("ld11.hour", 32'(hour), 32'd59);
`else
      chk("ld11.hour", 32'(hour), 32'd55);
`endif
      n_pulse = 0;
      step(10);
      chk_time("roll", 6'd0, 6'd0, 6'd0);
      chk("roll.pulses", 32'(n_pulse), 32'd1);

      n_err = 0;
      load(5'd5, 6'd60, 6'd10);
      chk("bad.load_err", 32'(load_err), 32'd1);
      chk_time("bad", 6'd0, 6'd0, 6'd0);
      chk("bad.synced", 32'(synced), 32'd1);
      step(1);
      chk("bad.load_err_off", 32'(load_err), 32'd0);
      chk("bad.err_count", 32'(n_err), 32'd1);

      load(5'd2, 6'd10, 6'd20);
      step(9);
      load(5'd4, 6'd30, 6'd0);
      chk("ow.pulse", 32'(sec_pulse), 32'd0);
`ifdef CLK_TIMEKEEPER_SMOOTH_HOUR_EN
      chk_time("ow", 6'd22, 6'd30, 6'd0);
`else
      chk_time("ow", 6'd20, 6'd30, 6'd0);
`endif
      chk("ow.synccounter", 32'(synccounter), 32'd0);
      n_pulse = 0;
      step(9);
      chk("ow.c9.pulses", 32'(n_pulse), 32'd0);
      step(1);
      chk("ow.c10.pulse", 32'(sec_pulse), 32'd1);
      chk("ow.c10.second", 32'(second), 32'd1);

      step(9);
      load(5'd24, 6'd0, 6'd0);
      chk("rw.load_err", 32'(load_err), 32'd1);
      chk("rw.pulse", 32'(sec_pulse), 32'd1);
      chk("rw.second", 32'(second), 32'd2);

      load(5'd3, 6'd36, 6'd0);
`ifdef CLK_TIMEKEEPER_SMOOTH_HOUR_EN
      chk("ld3.hour", 32'(hour), 32'd18);
`else
      chk("ld3.hour", 32'(hour), 32'd15);
`endif
      step(4);
      reset      = 1'b1;
      load_valid = 1'b1;
      hour_in    = 5'd7;
      minute_in  = 6'd20;
      second_in  = 6'd30;
      step(1);
      reset      = 1'b0;
      load_valid = 1'b0;
      chk_time("mrst", 6'd0, 6'd0, 6'd0);
      chk("mrst.synced", 32'(synced), 32'd0);
      chk("mrst.synccounter", 32'(synccounter), 32'd0);
      chk("mrst.pulse", 32'(sec_pulse), 32'd0);
      n_pulse = 0;
      step(20);
      chk("mrst.idle.pulses", 32'(n_pulse), 32'd0);
      load(5'd0, 6'd0, 6'd0);
      step(9);
      chk("mrst.c9.second", 32'(second), 32'd0);
      chk("mrst.c9.pulses", 32'(n_pulse), 32'd0);
      step(1);
      chk("mrst.c10.second", 32'(second), 32'd1);
      chk("mrst.c10.pulse", 32'(sec_pulse), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/clk_timekeeper.md
CLK_TIMEKEEPER -- requirements
Module: clk_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 40000000, meaning clk cycles per second.
REQ-002 SHALL have parameter SYNC_W, default 16, meaning the width of the seconds-since-sync counter.
REQ-003 SHALL have port clk, input, 1 bit: system clock; rising edge only.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: one-cycle pulse carrying a new time frame, already synchronised to clk.
REQ-006 SHALL have port hour_in, input, 5 bits: hour, 0-23.
REQ-007 SHALL have port minute_in, input, 6 bits: minute, 0-59.
REQ-008 SHALL have port second_in, input, 6 bits: second, 0-59.
REQ-009 SHALL have port second, output, 6 bits: second-hand tick position, 0-59.
REQ-010 SHALL have port minute, output, 6 bits: minute-hand tick position, 0-59.
REQ-011 SHALL have port hour, output, 6 bits: hour-hand tick position, 0-59.
REQ-012 SHALL have port sec_pulse, output, 1 bit: one-cycle pulse on each running-second increment.
REQ-013 SHALL have port synced, output, 1 bit: high once a valid frame has been loaded.
REQ-014 SHALL have port load_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-015 SHALL have port synccounter, output, SYNC_W bits: seconds elapsed since the last accepted load; saturates.

Function
REQ-016 SHALL implement FSM states UNSYNCED and RUNNING; UNSYNCED -> RUNNING on an accepted load; RUNNING -> RUNNING on an accepted load; no other transitions except reset.
REQ-017 In UNSYNCED, the prescaler and time registers SHALL hold, sec_pulse SHALL stay 0, and synced SHALL be 0.
REQ-018 A load SHALL be accepted iff load_valid=1, minute_in<=59, second_in<=59 and hour_in<=23.
REQ-019 Otherwise load_valid=1 SHALL pulse load_err the next cycle and change no other state.
REQ-020 An accepted load SHALL store hour_in mod 12 (12-23 -> 0-11), minute_in and second_in.
REQ-021 An accepted load SHALL clear the prescaler and synccounter.
REQ-022 An accepted load SHALL appear on the outputs on the cycle after load_valid (latency 1).
REQ-023 In RUNNING, the prescaler SHALL count 0..CLK_HZ-1; at CLK_HZ-1 it SHALL wrap to 0 and the seconds SHALL increment, with sec_pulse high that same following cycle.
REQ-024 Rollover SHALL be second 59->0 carrying to minute, minute 59->0 carrying to hour, and hour 11->0 (11:59:59 -> 00:00:00).
REQ-025 synccounter SHALL increment on each second increment and saturate at all-ones.
REQ-026 If an accepted load coincides with a prescaler wrap, the load SHALL win: no increment, no sec_pulse.
REQ-027 A rejected load coinciding with a wrap SHALL NOT suppress the increment.
REQ-028 second and minute SHALL equal the stored second and minute directly; the hour mapping SHALL be per REQ-033/REQ-034.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset SHALL be synchronous and active-high and SHALL override load_valid in the same cycle.
REQ-031 After reset: state=UNSYNCED; prescaler, second, minute, hour, synccounter = 0; sec_pulse, load_err, synced = 0.
REQ-032 Reset asserted mid-count SHALL discard the partial second; the next second SHALL require a new load plus a full CLK_HZ cycles.

Configuration
REQ-033 With macro CLK_TIMEKEEPER_SMOOTH_HOUR_EN defined, hour SHALL equal stored_hour*5 + stored_minute/12 (integer division; range 0-59).
REQ-034 Without CLK_TIMEKEEPER_SMOOTH_HOUR_EN, hour SHALL equal stored_hour*5 (range 0-55, steps of 5).

Structure
REQ-035 Shared package clk_pkg SHALL hold TICKS_PER_REV=60, SEC_MAX=59, MIN_MAX=59, HR12_MAX=11, and the FSM state enum tk_state_t.
REQ-036 Sub-module sec_prescaler SHALL be used (inputs clk, reset, en, clr; output wrap; parameter CLK_HZ); all time arithmetic stays in clk_timekeeper.

Verification (CLK_HZ=10 for simulation)
REQ-037 Reset, then 50 idle cycles -> synced=0; sec_pulse never asserted; all outputs 0.
REQ-038 load 13:07:58 -> next cycle hour_in stored as 1, minute=7, second=58, synced=1; after 10 cycles second=59; after 20 cycles second=0, minute=8, synccounter=2.
REQ-039 load 11:59:59, then wait 10 cycles -> second=0, minute=0, hour=0, one sec_pulse.
REQ-040 load minute_in=60 -> load_err pulses once; time and synced unchanged.
REQ-041 Accepted load on the wrap cycle -> no sec_pulse; loaded values shown; next pulse comes 10 cycles later.
REQ-042 load 3:36:00 -> hour=18 with CLK_TIMEKEEPER_SMOOTH_HOUR_EN, hour=15 without; reset asserted mid-second -> REQ-031 values next cycle.
